// File: rtl/input_capture_mc.sv
// Multi-channel input capture: synchronised pins, per-channel edge select, event counter, timestamp.
// Event latency SYNC_STAGES cycles (+FILT_LEN with INPUT_CAPTURE_FILTER_EN); no backpressure, events never stall.
module input_capture_mc #(
  parameter int CH_NUM      = 4,
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 4
) (
  input  logic                      i_sysclk,
  input  logic                      i_sysrst,
  input  logic                      i_cnt_en,
  input  logic                      i_clr,
  input  logic [CH_NUM-1:0]         i_cap_pin,
  input  logic [2*CH_NUM-1:0]       i_edge_mode,
  input  logic [CH_NUM-1:0]         i_ack,
  output logic [CH_NUM-1:0]         o_ic_flg,
  output logic [CH_NUM-1:0]         o_pend,
  output logic [CH_NUM-1:0]         o_ovr,
  output logic [CH_NUM*CNT_W-1:0]   o_cnt_data,
  output logic [CH_NUM*CNT_W-1:0]   o_cap_data,
  output logic [CNT_W-1:0]          o_tb,
  output logic                      o_tb_ovf
);

  localparam logic [CNT_W-1:0] TB_MAX = '1;

  if (CH_NUM < 1 || CH_NUM > 16 || CNT_W < 8 || CNT_W > 32 ||
      SYNC_STAGES < 2 || FILT_LEN < 1) begin : g_bad_param
    $error("input_capture_mc: parameter out of range");
  end

  logic [CNT_W-1:0] r_tb;
  logic             r_tb_ovf;

  always_ff @(posedge i_sysclk) begin
    if (i_sysrst || i_clr) begin
      r_tb     <= '0;
      r_tb_ovf <= 1'b0;
    end else begin
      r_tb_ovf <= i_cnt_en && (r_tb == TB_MAX);
      if (i_cnt_en) begin
        r_tb <= r_tb + CNT_W'(1);
      end
    end
  end

  assign o_tb     = r_tb;
  assign o_tb_ovf = r_tb_ovf;

  for (genvar n = 0; n < CH_NUM; n++) begin : g_ch
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_lvl;
    logic                   r_prev;
    logic [1:0]             w_mode;
    logic                   w_rise;
    logic                   w_fall;
    logic                   w_evt;
    logic                   r_flg;
    logic                   r_pend;
    logic                   r_ovr;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       r_cap;

    // Synchroniser and prev-level keep running through i_clr and i_cnt_en=0 so no stale edge survives.
    always_ff @(posedge i_sysclk) begin
      if (i_sysrst) begin
        r_sync <= '0;
      end else begin
        r_sync <= {r_sync[SYNC_STAGES-2:0], i_cap_pin[n]};
      end
    end

`ifdef INPUT_CAPTURE_FILTER_EN
    localparam int FC_W = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
    logic [FC_W-1:0] r_fcnt;
    logic            r_filt;

    always_ff @(posedge i_sysclk) begin
      if (i_sysrst) begin
        r_filt <= 1'b0;
        r_fcnt <= '0;
      end else if (r_sync[SYNC_STAGES-1] == r_filt) begin
        r_fcnt <= '0;
      end else if (r_fcnt == FC_W'(FILT_LEN - 1)) begin
        r_filt <= r_sync[SYNC_STAGES-1];
        r_fcnt <= '0;
      end else begin
        r_fcnt <= r_fcnt + FC_W'(1);
      end
    end

    assign w_lvl = r_filt;
`else
    assign w_lvl = r_sync[SYNC_STAGES-1];
`endif

    always_ff @(posedge i_sysclk) begin
      if (i_sysrst) begin
        r_prev <= 1'b0;
      end else begin
        r_prev <= w_lvl;
      end
    end

    assign w_mode = i_edge_mode[2*n +: 2];
    assign w_rise = w_lvl & ~r_prev;
    assign w_fall = ~w_lvl & r_prev;
    assign w_evt  = i_cnt_en & ((w_mode[0] & w_rise) | (w_mode[1] & w_fall));

    // An ack coinciding with a new event consumes the old one; the new event stays pending.
    always_ff @(posedge i_sysclk) begin
      if (i_sysrst || i_clr) begin
        r_flg  <= 1'b0;
        r_pend <= 1'b0;
        r_ovr  <= 1'b0;
        r_cnt  <= '0;
        r_cap  <= '0;
      end else begin
        r_flg <= w_evt;
        if (w_evt) begin
          r_cnt  <= r_cnt + CNT_W'(1);
          r_cap  <= r_tb;
          r_pend <= 1'b1;
          if (r_pend && !i_ack[n]) begin
            r_ovr <= 1'b1;
          end
        end else if (i_ack[n]) begin
          r_pend <= 1'b0;
        end
      end
    end

    assign o_ic_flg[n]                   = r_flg;
    assign o_pend[n]                     = r_pend;
    assign o_ovr[n]                      = r_ovr;
    assign o_cnt_data[n*CNT_W +: CNT_W]  = r_cnt;
    assign o_cap_data[n*CNT_W +: CNT_W]  = r_cap;
  end

endmodule
